// File: rtl/prf_regfile_if.sv
// Register-file access bundle: read lookups, writeback writes, rename allocations and flush.
// The core side drives through the master modport; the register file sits on the slave modport.
interface prf_regfile_if #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int NUM_RD    = 6,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 3
);
    localparam int AW = $clog2(DEPTH);

    logic                        flush_i;
    logic [NUM_RD*AW-1:0]        rd_addr_i;
    logic [NUM_RD*WIDTH-1:0]     rd_data_o;
    logic [NUM_RD-1:0]           rd_ready_o;
    logic [NUM_WR-1:0]           wr_en_i;
    logic [NUM_WR*AW-1:0]        wr_addr_i;
    logic [NUM_WR*WIDTH-1:0]     wr_data_i;
    logic [NUM_ALLOC-1:0]        alloc_en_i;
    logic [NUM_ALLOC*AW-1:0]     alloc_addr_i;

    modport master (
        output flush_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
        input  rd_data_o, rd_ready_o
    );

    modport slave (
        input  flush_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
        output rd_data_o, rd_ready_o
    );
endinterface

// File: rtl/prf_regfile.sv
// Physical register file with per-entry ready bits, multi-port writeback, rename allocation,
// flush, and optional same-cycle write-to-read forwarding. Entry 0 is the constant-zero register.
module prf_regfile #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int NUM_RD    = 6,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 3,
    parameter int BYPASS    = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    prf_regfile_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] ready_d;

    logic [AW-1:0]    rd_addr    [NUM_RD];
    logic [WIDTH-1:0] rd_data    [NUM_RD];
    logic             rd_ready   [NUM_RD];
    logic [AW-1:0]    wr_addr    [NUM_WR];
    logic [WIDTH-1:0] wr_data    [NUM_WR];
    logic [AW-1:0]    alloc_addr [NUM_ALLOC];

    // Unpack the flat bus vectors into per-port arrays.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_addr[k]                        = bus.rd_addr_i[k*AW +: AW];
        assign bus.rd_data_o[k*WIDTH +: WIDTH]   = rd_data[k];
        assign bus.rd_ready_o[k]                 = rd_ready[k];
    end
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wr_addr[j] = bus.wr_addr_i[j*AW +: AW];
        assign wr_data[j] = bus.wr_data_i[j*WIDTH +: WIDTH];
    end
    for (genvar m = 0; m < NUM_ALLOC; m++) begin : g_alloc
        assign alloc_addr[m] = bus.alloc_addr_i[m*AW +: AW];
    end

    // Next state: writes in ascending port order so the highest port wins, then flush or allocs,
    // so an alloc overrides the ready bit a same-cycle write would set.
    always_comb begin
        // NOTE: every always_comb output gets a full default first; without it any path that skips
        // an assignment would infer a latch.
        data_d  = data_q;
        ready_d = ready_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en_i[j] && wr_addr[j] != '0) begin
                data_d[wr_addr[j]]  = wr_data[j];
                ready_d[wr_addr[j]] = 1'b1;
            end
        end
        if (bus.flush_i) begin
            ready_d = '1;
        end else begin
            for (int m = 0; m < NUM_ALLOC; m++) begin
                if (bus.alloc_en_i[m] && alloc_addr[m] != '0) begin
                    ready_d[alloc_addr[m]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the storage array is reset on purpose: reset must clear every entry at once,
            // which forces flops rather than a RAM macro for this file.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            ready_q <= '1;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    // Reads: stored state, optionally overridden by the winning same-cycle write; address 0 is forced.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k]  = data_q[rd_addr[k]];
            rd_ready[k] = ready_q[rd_addr[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en_i[j] && wr_addr[j] == rd_addr[k]) begin
                        rd_data[k]  = wr_data[j];
                        rd_ready[k] = 1'b1;
                    end
                end
            end
            if (rd_addr[k] == '0) begin
                rd_data[k]  = '0;
                rd_ready[k] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prf_regfile.sv
// Directed bench: one forwarding and one non-forwarding register file driven in lockstep,
// checked against hand-computed vectors plus reset and flush sequences.
module tb_prf_regfile;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 64;
    localparam int AW        = 6;
    localparam int NUM_RD    = 6;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 3;
    localparam int NVEC      = 15;

    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    prf_regfile_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                     .NUM_ALLOC(NUM_ALLOC)) bus_bp ();
    prf_regfile_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                     .NUM_ALLOC(NUM_ALLOC)) bus_nb ();

    prf_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                  .NUM_ALLOC(NUM_ALLOC), .BYPASS(1)) u_bp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus_bp.slave)
    );

    prf_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                  .NUM_ALLOC(NUM_ALLOC), .BYPASS(0)) u_nb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus_nb.slave)
    );

    assign bus_nb.flush_i      = bus_bp.flush_i;
    assign bus_nb.rd_addr_i    = bus_bp.rd_addr_i;
    assign bus_nb.wr_en_i      = bus_bp.wr_en_i;
    assign bus_nb.wr_addr_i    = bus_bp.wr_addr_i;
    assign bus_nb.wr_data_i    = bus_bp.wr_data_i;
    assign bus_nb.alloc_en_i   = bus_bp.alloc_en_i;
    assign bus_nb.alloc_addr_i = bus_bp.alloc_addr_i;

    typedef struct {
        logic [1:0]       we;
        logic [AW-1:0]    wa0;
        logic [WIDTH-1:0] wd0;
        logic [AW-1:0]    wa1;
        logic [WIDTH-1:0] wd1;
        logic [2:0]       ae;
        logic [AW-1:0]    aa0;
        logic [AW-1:0]    aa1;
        logic [AW-1:0]    aa2;
        logic             fl;
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] bp_d;
        logic             bp_r;
        logic [WIDTH-1:0] nb_d;
        logic             nb_r;
    } row_t;

    row_t vec [NVEC];

    function automatic row_t mk(input logic [1:0] we, input logic [AW-1:0] wa0,
                                input logic [WIDTH-1:0] wd0, input logic [AW-1:0] wa1,
                                input logic [WIDTH-1:0] wd1, input logic [2:0] ae,
                                input logic [AW-1:0] aa0, input logic [AW-1:0] aa1,
                                input logic [AW-1:0] aa2, input logic fl, input logic [AW-1:0] ra,
                                input logic [WIDTH-1:0] bp_d, input logic bp_r,
                                input logic [WIDTH-1:0] nb_d, input logic nb_r);
        row_t r;
        r.we = we;   r.wa0 = wa0; r.wd0 = wd0; r.wa1 = wa1; r.wd1 = wd1;
        r.ae = ae;   r.aa0 = aa0; r.aa1 = aa1; r.aa2 = aa2; r.fl = fl;
        r.ra = ra;   r.bp_d = bp_d; r.bp_r = bp_r; r.nb_d = nb_d; r.nb_r = nb_r;
        return r;
    endfunction

    function automatic row_t idle_row(input logic [AW-1:0] ra, input logic [WIDTH-1:0] d,
                                      input logic r);
        return mk(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, ra, d, r, d, r);
    endfunction

    task automatic apply(input row_t r);
        bus_bp.wr_en_i      = r.we;
        bus_bp.wr_addr_i    = {r.wa1, r.wa0};
        bus_bp.wr_data_i    = {r.wd1, r.wd0};
        bus_bp.alloc_en_i   = r.ae;
        bus_bp.alloc_addr_i = {r.aa2, r.aa1, r.aa0};
        bus_bp.flush_i      = r.fl;
        bus_bp.rd_addr_i    = {NUM_RD{r.ra}};
    endtask

    task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got data=%h ready=%b, expected data=%h ready=%b",
                     name, got[WIDTH:1], got[0], exp[WIDTH:1], exp[0]);
        end
    endtask

    task automatic check_ports(input string tag,
                               input logic [NUM_RD*WIDTH-1:0] bd, input logic [NUM_RD-1:0] br,
                               input logic [NUM_RD*WIDTH-1:0] nd, input logic [NUM_RD-1:0] nr);
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("%s bypass port%0d", tag, k),
                  {bus_bp.rd_data_o[k*WIDTH +: WIDTH], bus_bp.rd_ready_o[k]},
                  {bd[k*WIDTH +: WIDTH], br[k]});
            check($sformatf("%s nobypass port%0d", tag, k),
                  {bus_nb.rd_data_o[k*WIDTH +: WIDTH], bus_nb.rd_ready_o[k]},
                  {nd[k*WIDTH +: WIDTH], nr[k]});
        end
    endtask

    initial begin
        // Each row drives one cycle; reads are checked before the edge that commits the row.
        vec[0]  = mk(2'b01, 6'd0, 32'h1234, 6'd0, 32'h0, 3'b001, 6'd0, 6'd0, 6'd0, 1'b0,
                     6'd0, 32'h0, 1'b1, 32'h0, 1'b1);
        vec[1]  = idle_row(6'd0, 32'h0, 1'b1);
        vec[2]  = mk(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 3'b001, 6'd7, 6'd0, 6'd0, 1'b0,
                     6'd7, 32'h0, 1'b1, 32'h0, 1'b1);
        vec[3]  = idle_row(6'd7, 32'h0, 1'b0);
        vec[4]  = idle_row(6'd7, 32'h0, 1'b0);
        vec[5]  = mk(2'b01, 6'd7, 32'hA5A5_0001, 6'd0, 32'h0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0,
                     6'd7, 32'hA5A5_0001, 1'b1, 32'h0, 1'b0);
        vec[6]  = idle_row(6'd7, 32'hA5A5_0001, 1'b1);
        vec[7]  = mk(2'b11, 6'd9, 32'h11, 6'd9, 32'h22, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0,
                     6'd9, 32'h22, 1'b1, 32'h0, 1'b1);
        vec[8]  = idle_row(6'd9, 32'h22, 1'b1);
        vec[9]  = mk(2'b10, 6'd0, 32'h0, 6'd12, 32'h77, 3'b100, 6'd0, 6'd0, 6'd12, 1'b0,
                     6'd12, 32'h77, 1'b1, 32'h0, 1'b1);
        vec[10] = idle_row(6'd12, 32'h77, 1'b0);
        vec[11] = mk(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 3'b101, 6'd15, 6'd0, 6'd15, 1'b0,
                     6'd15, 32'h0, 1'b1, 32'h0, 1'b1);
        vec[12] = idle_row(6'd15, 32'h0, 1'b0);
        vec[13] = mk(2'b10, 6'd0, 32'h0, 6'd15, 32'hCAFE, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0,
                     6'd15, 32'hCAFE, 1'b1, 32'h0, 1'b0);
        vec[14] = idle_row(6'd15, 32'hCAFE, 1'b1);

        reset_i = 1'b1;
        apply(idle_row(6'd0, 32'h0, 1'b1));
        bus_bp.rd_addr_i = {6'd63, 6'd62, 6'd33, 6'd5, 6'd1, 6'd0};
        #2;
        check_ports("reset state", '0, '1, '0, '1);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Asynchronous reset in the middle of a cycle clears a freshly written entry.
        @(negedge clk_i);
        apply(mk(2'b01, 6'd5, 32'hDEAD_BEEF, 6'd0, 32'h0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0,
                 6'd5, 32'h0, 1'b1, 32'h0, 1'b1));
        #2;
        check_ports("p5 write", {NUM_RD{32'hDEAD_BEEF}}, '1, '0, '1);
        @(negedge clk_i);
        apply(idle_row(6'd5, 32'h0, 1'b1));
        #2;
        check_ports("p5 stored", {NUM_RD{32'hDEAD_BEEF}}, '1, {NUM_RD{32'hDEAD_BEEF}}, '1);
        reset_i = 1'b1;
        #1;
        check_ports("mid-cycle reset", '0, '1, '0, '1);
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            apply(vec[i]);
            #2;
            check_ports($sformatf("vec%0d", i), {NUM_RD{vec[i].bp_d}}, {NUM_RD{vec[i].bp_r}},
                        {NUM_RD{vec[i].nb_d}}, {NUM_RD{vec[i].nb_r}});
        end

        // Flush sequence: make six entries busy, then flush with a competing alloc and a write.
        @(negedge clk_i);
        apply(idle_row(6'd0, 32'h0, 1'b1));
        bus_bp.alloc_en_i   = 3'b111;
        bus_bp.alloc_addr_i = {6'd5, 6'd4, 6'd3};
        @(negedge clk_i);
        bus_bp.alloc_addr_i = {6'd12, 6'd9, 6'd7};
        @(negedge clk_i);
        apply(idle_row(6'd0, 32'h0, 1'b1));
        bus_bp.rd_addr_i = {6'd12, 6'd9, 6'd7, 6'd5, 6'd4, 6'd3};
        #2;
        check_ports("busy six",
                    {32'h77, 32'h22, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0}, '0,
                    {32'h77, 32'h22, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0}, '0);
        @(negedge clk_i);
        bus_bp.flush_i      = 1'b1;
        bus_bp.alloc_en_i   = 3'b011;
        bus_bp.alloc_addr_i = {6'd0, 6'd20, 6'd6};
        bus_bp.wr_en_i      = 2'b01;
        bus_bp.wr_addr_i    = {6'd0, 6'd20};
        bus_bp.wr_data_i    = {32'h0, 32'h55};
        @(negedge clk_i);
        apply(idle_row(6'd0, 32'h0, 1'b1));
        bus_bp.rd_addr_i = {6'd20, 6'd12, 6'd6, 6'd5, 6'd4, 6'd3};
        #2;
        check_ports("after flush",
                    {32'h55, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0}, '1,
                    {32'h55, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0}, '1);
        bus_bp.rd_addr_i = {6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd7};
        #1;
        check_ports("flush keeps data",
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h22, 32'hA5A5_0001}, '1,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h22, 32'hA5A5_0001}, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
